// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle RV32I core's load/store/fetch port.
// Accepts one request at a time, optionally inserts wait states, then performs
// a single-cycle access to a word-organised RAM. Stores write the selected
// byte lanes. Loads return sign- or zero-extended data.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE while out of reset, so at most one request is
// in flight and nothing is queued. The response is a one-cycle resp_valid
// strobe. resp_rdata/resp_err are meaningful only while resp_valid is high.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   synchronous reset, active low
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept (IDLE and not in reset)
//   req_we      in   1   1 = store, 0 = load/fetch
//   req_addr    in   32  byte address
//   req_funct3  in   3   RV32I size/sign code
//   req_wdata   in   32  store data, right-aligned
//   resp_valid  out  1   one-cycle response strobe
//   resp_rdata  out  32  extended load data, 0 for stores and errors
//   resp_err    out  1   misaligned, out-of-range or illegal funct3
//   dbg_state   out  2   current FSM state (IDLE=0, WAIT=1, ACCESS=2, RESP=3)
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched request
    logic          r_we;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [2:0]    r_funct3;
    logic [31:0]   r_wdata;

    logic [3:0]    r_wait_cnt;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic [31:0]   r_mem [DEPTH];

    logic          w_hs;
    logic [31:0]   w_word_idx;
    logic          w_oob;
    logic          w_misalign;
    logic          w_illegal;
    logic          w_req_err;

    logic [31:0]   w_rword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;

    // ------------------------------------------------------------------------
    // Request checking, done on the request as it is accepted
    // ------------------------------------------------------------------------
    always_comb begin
        w_hs       = req_valid && req_ready;
        w_word_idx = {2'b00, req_addr[31:2]};
        w_oob      = (w_word_idx >= DEPTH);
        w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (req_we) begin
            w_illegal = (req_funct3 > 3'b010);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        w_req_err  = w_oob || w_misalign || w_illegal;
    end

    // ------------------------------------------------------------------------
    // Next-state logic and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = (r_state == S_IDLE) && rst;
        resp_valid  = (r_state == S_RESP);
        dbg_state   = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    if (w_req_err) begin
                        w_state_nxt = S_RESP;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                // Counter starts at WAIT_STATES, so WAIT lasts that many cycles.
                if (r_wait_cnt <= 4'd1) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Load path: select byte/half from the addressed word and extend
    // ------------------------------------------------------------------------
    always_comb begin
        w_rword = r_mem[r_idx];
        case (r_off)
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
        w_half = r_off[1] ? w_rword[31:16] : w_rword[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_rword;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Store path: byte-lane enables and data replicated onto every lane
    // ------------------------------------------------------------------------
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << r_off;
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = r_off[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = r_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and response datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_we       <= req_we;
                        r_idx      <= req_addr[AW+1:2];
                        r_off      <= req_addr[1:0];
                        r_funct3   <= req_funct3;
                        r_wdata    <= req_wdata;
                        r_wait_cnt <= 4'(WAIT_STATES);
                        if (w_req_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                end
                S_ACCESS: begin
                    r_err   <= 1'b0;
                    r_rdata <= r_we ? 32'd0 : w_load;
                end
                default: begin
                end
            endcase
        end
    end

    // Array is not reset. A store whose ACCESS edge sees reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && (r_state == S_ACCESS) && r_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
